muldiv_hilo_unit: RTL and testbench
===================================

Name: muldiv_hilo_unit

Overview:
Parametrised sequential multiply/divide unit with architectural HI/LO registers. It is the multi-cycle companion to the single-cycle ALU datapath and shares the same function-code encoding. It executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, under a start/busy/done handshake. MFHI and MFLO read the committed results.

Parameters:
WIDTH, 32, operand width in bits (minimum 4); the product is 2*WIDTH bits wide and is split across HI:LO.

Ports:
clk      input   1      system clock, rising-edge
reset    input   1      asynchronous, active-low reset
start    input   1      request; sampled only in IDLE or DONE
Signal   input   6      function code: 24 MULT, 25 MULTU, 26 DIV, 27 DIVU, 16 MFHI, 18 MFLO
dataA    input   WIDTH  multiplicand / dividend
dataB    input   WIDTH  multiplier / divisor
busy     output  1      operation in progress
done     output  1      one-cycle completion pulse
dbz      output  1      divide-by-zero flag for the last committed operation
Output   output  WIDTH  HI when Signal=16, LO when Signal=18, else 0 (combinational)

Behaviour:
- Reset: reset=0 forces, at any time and including mid-operation:
  - state=IDLE, HI=0, LO=0, busy=0, done=0, dbz=0, counter=0, all working registers 0.
  - An in-flight operation is discarded and is never committed.
- States: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN: at an edge with start=1 and Signal in {24,25,26,27}.
  - RUN -> DONE: at the edge completing iteration WIDTH.
  - DONE -> IDLE: when start is not accepted; DONE -> RUN when a new start is accepted (back-to-back).
  - start with any other Signal value is ignored. start during RUN is ignored.
- Acceptance edge (edge 0):
  - Latch the operands.
  - For signed ops (24, 26), convert each operand to magnitude and latch the result sign(s).
  - Clear the counter.
  - busy=1 from this edge.
- Iterations: each RUN edge performs one step; edges 1..WIDTH.
  - Multiply: unsigned shift-add over magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; quotient in the low half, partial remainder in the high half.
- Commit (edge WIDTH):
  - HI/LO are written, state=DONE, busy=0, done=1 for exactly one cycle.
  - Results are visible via MFHI/MFLO from edge WIDTH; total latency is WIDTH cycles from acceptance.
- Multiply results:
  - HI:LO = full 2*WIDTH product.
  - MULT negates the 2*WIDTH product when the operand signs differ.
- Divide results:
  - LO = quotient, HI = remainder.
  - DIV truncates toward zero: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Most-negative / -1: LO = most-negative value (wraps), HI = 0; no flag.
- Divide by zero (dataB=0 on DIV/DIVU):
  - Normal WIDTH-cycle latency.
  - Commit HI = dataA as latched, LO = all ones, dbz=1.
- dbz: updated only at commit; cleared by any non-zero-divisor commit.
- HI/LO hold their previous values throughout RUN. MFHI/MFLO during RUN return the old values, never partial results.
- Output decode is purely combinational from Signal, HI and LO; it is independent of state.

Test Plan:
- Reset mid-operation:
  - Stimulus: HI=5, LO=9 committed; MULTU start; reset=0 asserted asynchronously at cycle 10.
  - Response: busy=0 immediately; HI=LO=0. After release, no done pulse occurs.
  - Stimulus: a start issued in the middle of a RUN.
  - Response: ignored; MFHI during RUN returns 5.
- MULTU (WIDTH=32):
  - Stimulus: 0xFFFFFFFF * 0xFFFFFFFF, start at edge 0.
  - Response: busy on edges 0..31; done=1 after edge 32; MFHI=0xFFFFFFFE, MFLO=0x00000001.
- MULT (WIDTH=32):
  - Stimulus: -3 * 5.
  - Response: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Stimulus: back-to-back MULT 7 * -1, start asserted in the DONE cycle.
  - Response: accepted without an IDLE gap; LO=0xFFFFFFF9.
- DIVU / DIV (WIDTH=32):
  - Stimulus: DIVU 100 / 7.
  - Response: LO=14, HI=2, dbz=0.
  - Stimulus: DIV -7 / 2.
  - Response: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Stimulus: DIV 0x80000000 / -1.
  - Response: LO=0x80000000, HI=0.
- Divide by zero (WIDTH=32):
  - Stimulus: DIVU 1234 / 0.
  - Response: done after 32 cycles; dbz=1, HI=1234, LO=0xFFFFFFFF.
  - Stimulus: next DIVU 9 / 3.
  - Response: dbz=0, LO=3.
- WIDTH=8 instance:
  - Stimulus: MULTU 255 * 255.
  - Response: HI=0xFE, LO=0x01 after 8 cycles.
  - Stimulus: Signal=32 with start=1.
  - Response: ignored; Output=0.

Source files
------------

// File: rtl/muldiv_hilo_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit with HI/LO.
// The master drives the request fields and the slave returns status and the MFHI/MFLO read data.
interface muldiv_hilo_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       Signal;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] Output;

  modport master (output start, Signal, dataA, dataB, input busy, done, dbz, Output);
  modport slave  (input start, Signal, dataA, dataB, output busy, done, dbz, Output);
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU, one bit per cycle, committing into HI/LO.
// Signed ops run on magnitudes; the sign fix-up is applied in the commit cycle.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_hilo_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               zdiv_q, zdiv_d;
  logic               dbz_q, dbz_d;

  logic               is_divop, is_signed, is_op, accept;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, trial;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   q_raw, r_raw, quo, rem;

  always_comb begin
    is_divop  = (bus.Signal == F_DIV) || (bus.Signal == F_DIVU);
    is_signed = (bus.Signal == F_MULT) || (bus.Signal == F_DIV);
    is_op     = is_divop || (bus.Signal == F_MULT) || (bus.Signal == F_MULTU);
    accept    = bus.start && is_op && (state_q != RUN);
    sa        = is_signed && bus.dataA[WIDTH-1];
    sb        = is_signed && bus.dataB[WIDTH-1];
    mag_a     = sa ? -bus.dataA : bus.dataA;
    mag_b     = sb ? -bus.dataB : bus.dataB;
  end

  // Multiply: acc low half holds the multiplier, shifted out LSB-first while
  // partial sums enter the high half. Divide: acc = {partial remainder, quotient}.
  always_comb begin
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
    if (is_div_q)
      acc_step = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                              : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_step = {add_sum, acc_q[WIDTH-1:1]};
    prod  = neg_q ? -acc_step : acc_step;
    q_raw = acc_step[WIDTH-1:0];
    r_raw = acc_step[2*WIDTH-1:WIDTH];
    quo   = neg_q ? -q_raw : q_raw;
    rem   = rneg_q ? -r_raw : r_raw;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    opa_d    = opa_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    zdiv_d   = zdiv_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d  = RUN;
          cnt_d    = '0;
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          opb_d    = mag_b;
          opa_d    = bus.dataA;
          is_div_d = is_divop;
          neg_d    = sa ^ sb;
          rneg_d   = sa;
          zdiv_d   = is_divop && (bus.dataB == '0);
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          dbz_d   = zdiv_q;
          if (zdiv_q) begin
            hi_d = opa_q;
            lo_d = '1;
          end else if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            {hi_d, lo_d} = prod;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      opa_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      zdiv_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      opa_q    <= opa_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      zdiv_q   <= zdiv_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.dbz    = dbz_q;
  assign bus.Output = (bus.Signal == F_MFHI) ? hi_q :
                      (bus.Signal == F_MFLO) ? lo_q : '0;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: 32-bit and 8-bit instances on one clock.
// Expected HI/LO/dbz are queued at issue and popped when done is seen.
module tb_muldiv_hilo_unit;
  localparam logic [5:0] F_MULT = 6'd24, F_MULTU = 6'd25, F_DIV = 6'd26, F_DIVU = 6'd27;
  localparam logic [5:0] F_MFHI = 6'd16, F_MFLO = 6'd18;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_hilo_unit_if #(.WIDTH(32)) b32();
  muldiv_hilo_unit_if #(.WIDTH(8))  b8();
  muldiv_hilo_unit #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32));
  muldiv_hilo_unit #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8));

  typedef struct { logic [31:0] hi; logic [31:0] lo; logic dbz; } exp_t;
  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue32(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
    b32.start = 1'b1; b32.Signal = sig; b32.dataA = a; b32.dataB = b;
    tick();
    b32.start = 1'b0; b32.Signal = 6'd0;
  endtask

  // Returns edges elapsed until done and how many of the samples before it saw busy.
  task automatic wait_done32(output int cyc, output int nb);
    cyc = 0; nb = 0;
    while (!b32.done && cyc < 200) begin
      if (b32.busy) nb++;
      tick();
      cyc++;
    end
  endtask

  task automatic read32(output logic [31:0] hi, output logic [31:0] lo);
    b32.Signal = F_MFHI; #1 hi = b32.Output;
    b32.Signal = F_MFLO; #1 lo = b32.Output;
    b32.Signal = 6'd0;
  endtask

  task automatic test_reset();
    int cyc, nb, ndone;
    logic [31:0] hi, lo;
    exp_t e;
    #12;
    checks++; if (b32.busy !== 1'b0 || b32.done !== 1'b0 || b32.dbz !== 1'b0) begin
      errors++; $display("FAIL rst_status: busy/done/dbz=%b%b%b want 000", b32.busy, b32.done, b32.dbz); end
    read32(hi, lo);
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL rst_hilo: hi=%h lo=%h want 0/0", hi, lo); end
    tick(); reset = 1'b1; tick();
    sb_q.push_back('{32'd5, 32'd9, 1'b0});
    issue32(F_DIVU, 32'd59, 32'd6);
    wait_done32(cyc, nb);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL seed_latency: got %0d want 32", cyc); end
    e = sb_q.pop_front(); read32(hi, lo);
    checks++; if (hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL seed_hilo: hi=%h lo=%h want %h/%h", hi, lo, e.hi, e.lo); end
    tick();
    issue32(F_MULTU, 32'd3, 32'd4);
    repeat (4) tick();
    b32.start = 1'b1; b32.Signal = F_DIVU; b32.dataA = 32'd1; b32.dataB = 32'd1;
    tick();
    b32.start = 1'b0; b32.Signal = F_MFHI; #1;
    checks++; if (b32.Output !== 32'd5 || b32.busy !== 1'b1) begin
      errors++; $display("FAIL run_mfhi: Output=%h busy=%b want 5/1", b32.Output, b32.busy); end
    b32.Signal = 6'd0;
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (b32.busy !== 1'b0 || b32.done !== 1'b0) begin
      errors++; $display("FAIL rst_async: busy=%b done=%b want 0/0", b32.busy, b32.done); end
    read32(hi, lo);
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL rst_mid_hilo: hi=%h lo=%h want 0/0", hi, lo); end
    tick(); reset = 1'b1;
    ndone = 0;
    repeat (40) begin tick(); if (b32.done || b32.busy) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rst_discard: activity=%0d want 0", ndone); end
  endtask

  task automatic test_ignore();
    int cyc, nb;
    logic [31:0] hi, lo;
    exp_t e;
    sb_q.push_back('{32'h0000_0001, 32'hFFFF_FFFE, 1'b0});
    issue32(F_MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (3) tick();
    b32.start = 1'b1; b32.Signal = F_DIVU; b32.dataA = 32'd10; b32.dataB = 32'd3;
    tick();
    b32.start = 1'b0; b32.Signal = 6'd0;
    wait_done32(cyc, nb);
    checks++; if (cyc + 4 !== 32) begin errors++; $display("FAIL ignore_latency: got %0d want 32", cyc + 4); end
    e = sb_q.pop_front(); read32(hi, lo);
    checks++; if (hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL ignore_hilo: hi=%h lo=%h want %h/%h", hi, lo, e.hi, e.lo); end
    tick();
  endtask

  task automatic test_multu();
    int cyc, nb;
    logic [31:0] hi, lo;
    exp_t e;
    sb_q.push_back('{32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    issue32(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done32(cyc, nb);
    checks++; if (cyc !== 32 || nb !== 32) begin
      errors++; $display("FAIL multu_timing: done_at=%0d busy_cycles=%0d want 32/32", cyc, nb); end
    checks++; if (b32.busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b want 0", b32.busy); end
    e = sb_q.pop_front(); read32(hi, lo);
    checks++; if (hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL multu_hilo: hi=%h lo=%h want %h/%h", hi, lo, e.hi, e.lo); end
    tick();
    checks++; if (b32.done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", b32.done); end
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    logic [31:0] hi, lo;
    exp_t e;
    sb_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0});
    issue32(F_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done32(cyc, nb);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL mult_latency: got %0d want 32", cyc); end
    e = sb_q.pop_front(); read32(hi, lo);
    checks++; if (hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL mult_hilo: hi=%h lo=%h want %h/%h", hi, lo, e.hi, e.lo); end
    sb_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0});
    issue32(F_MULT, 32'd7, 32'hFFFF_FFFF);
    checks++; if (b32.busy !== 1'b1 || b32.done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b done=%b want 1/0", b32.busy, b32.done); end
    wait_done32(cyc, nb);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL b2b_latency: got %0d want 32", cyc); end
    e = sb_q.pop_front(); read32(hi, lo);
    checks++; if (hi !== e.hi || lo !== e.lo) begin
      errors++; $display("FAIL b2b_hilo: hi=%h lo=%h want %h/%h", hi, lo, e.hi, e.lo); end
    tick();
  endtask

  task automatic test_div();
    logic [5:0]  sig [4] = '{F_DIVU, F_DIV, F_DIV, F_DIV};
    logic [31:0] opa [4] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
    logic [31:0] opb [4] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] ehi [4] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd1};
    logic [31:0] elo [4] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD};
    int cyc, nb;
    logic [31:0] hi, lo;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{ehi[i], elo[i], 1'b0});
      issue32(sig[i], opa[i], opb[i]);
      wait_done32(cyc, nb);
      checks++; if (cyc !== 32) begin errors++; $display("FAIL div%0d_latency: got %0d want 32", i, cyc); end
      e = sb_q.pop_front(); read32(hi, lo);
      checks++; if (hi !== e.hi || lo !== e.lo || b32.dbz !== e.dbz) begin
        errors++; $display("FAIL div%0d_result: hi=%h lo=%h dbz=%b want %h/%h/%b", i, hi, lo, b32.dbz, e.hi, e.lo, e.dbz); end
      tick();
    end
  endtask

  task automatic test_dbz();
    int cyc, nb;
    logic [31:0] hi, lo;
    exp_t e;
    sb_q.push_back('{32'd1234, 32'hFFFF_FFFF, 1'b1});
    issue32(F_DIVU, 32'd1234, 32'd0);
    wait_done32(cyc, nb);
    checks++; if (cyc !== 32) begin errors++; $display("FAIL dbz_latency: got %0d want 32", cyc); end
    e = sb_q.pop_front(); read32(hi, lo);
    checks++; if (hi !== e.hi || lo !== e.lo || b32.dbz !== e.dbz) begin
      errors++; $display("FAIL dbz_result: hi=%h lo=%h dbz=%b want %h/%h/%b", hi, lo, b32.dbz, e.hi, e.lo, e.dbz); end
    tick();
    sb_q.push_back('{32'd0, 32'd3, 1'b0});
    issue32(F_DIVU, 32'd9, 32'd3);
    repeat (5) tick();
    checks++; if (b32.dbz !== 1'b1) begin errors++; $display("FAIL dbz_hold_run: got %b want 1", b32.dbz); end
    wait_done32(cyc, nb);
    e = sb_q.pop_front(); read32(hi, lo);
    checks++; if (hi !== e.hi || lo !== e.lo || b32.dbz !== e.dbz) begin
      errors++; $display("FAIL dbz_clear: hi=%h lo=%h dbz=%b want %h/%h/%b", hi, lo, b32.dbz, e.hi, e.lo, e.dbz); end
    tick();
    sb_q.push_back('{32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1});
    issue32(F_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_done32(cyc, nb);
    e = sb_q.pop_front(); read32(hi, lo);
    checks++; if (hi !== e.hi || lo !== e.lo || b32.dbz !== e.dbz) begin
      errors++; $display("FAIL dbz_signed: hi=%h lo=%h dbz=%b want %h/%h/%b", hi, lo, b32.dbz, e.hi, e.lo, e.dbz); end
    tick();
  endtask

  task automatic test_width8();
    int cyc, act;
    logic [7:0] hi, lo;
    exp_t e;
    sb_q.push_back('{32'h0000_00FE, 32'h0000_0001, 1'b0});
    b8.start = 1'b1; b8.Signal = F_MULTU; b8.dataA = 8'hFF; b8.dataB = 8'hFF;
    tick();
    b8.start = 1'b0; b8.Signal = 6'd0;
    cyc = 0;
    while (!b8.done && cyc < 100) begin tick(); cyc++; end
    checks++; if (cyc !== 8) begin errors++; $display("FAIL w8_latency: got %0d want 8", cyc); end
    e = sb_q.pop_front();
    b8.Signal = F_MFHI; #1 hi = b8.Output;
    b8.Signal = F_MFLO; #1 lo = b8.Output;
    checks++; if (hi !== e.hi[7:0] || lo !== e.lo[7:0]) begin
      errors++; $display("FAIL w8_hilo: hi=%h lo=%h want %h/%h", hi, lo, e.hi[7:0], e.lo[7:0]); end
    tick();
    b8.start = 1'b1; b8.Signal = 6'd32; b8.dataA = 8'd3; b8.dataB = 8'd4;
    tick();
    b8.start = 1'b0;
    checks++; if (b8.busy !== 1'b0 || b8.Output !== 8'd0) begin
      errors++; $display("FAIL w8_badop: busy=%b Output=%h want 0/00", b8.busy, b8.Output); end
    act = 0;
    repeat (12) begin tick(); if (b8.busy || b8.done) act++; end
    b8.Signal = F_MFHI; #1;
    checks++; if (act !== 0 || b8.Output !== 8'hFE) begin
      errors++; $display("FAIL w8_badop_hold: activity=%0d hi=%h want 0/fe", act, b8.Output); end
    b8.Signal = 6'd0;
  endtask

  initial begin
    b32.start = 1'b0; b32.Signal = 6'd0; b32.dataA = '0; b32.dataB = '0;
    b8.start  = 1'b0; b8.Signal  = 6'd0; b8.dataA  = '0; b8.dataB  = '0;
    reset = 1'b0;
    test_reset();
    test_ignore();
    test_multu();
    test_back_to_back();
    test_div();
    test_dbz();
    test_width8();
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d entries want 0", sb_q.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
